// File: rtl/ram_req_if.sv
// Command and read-response channels between a requester and ram_req_ctrl.
// The requester drives req_* and rsp_ready; the controller drives the rest.
interface ram_req_if #(
  parameter int ADDR  = 8,
  parameter int DATA  = 8,
  parameter int LEN_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [ADDR-1:0]  req_addr;
  logic [DATA-1:0]  req_wdata;
  logic [LEN_W-1:0] req_len;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [DATA-1:0]  rsp_data;
  logic             rsp_last;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request controller in front of a single-port synchronous RAM: single-beat writes,
// incrementing read bursts, and a credit-protected response FIFO for read data.
module ram_req_ctrl #(
  parameter int ADDR       = 8,
  parameter int DATA       = 8,
  parameter int LEN_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ram_req_if.slave        bus,
  output logic            ram_write_enable,
  output logic [ADDR-1:0] ram_address,
  output logic [DATA-1:0] ram_data_in,
  input  logic [DATA-1:0] ram_data_out,
  output logic            busy
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t           state, state_nxt;
  logic [ADDR-1:0]  cur_addr;
  logic [DATA-1:0]  wdata_q;
  logic [LEN_W-1:0] beats_left;
  logic             inflight;
  logic             inflight_last;

  logic [DATA:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_count;
  logic             fifo_empty;

  logic accept, credit, issue, push, pop;

  assign accept     = bus.req_valid && bus.req_ready;
  assign fifo_empty = (fifo_count == '0);
  // A beat already in flight has a FIFO slot reserved; same-cycle pops are ignored.
  assign credit     = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;
  assign issue      = (state == READ) && credit;
  assign push       = inflight;
  assign pop        = bus.rsp_valid && bus.rsp_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = bus.req_write ? WRITE : READ;
      WRITE:   state_nxt = IDLE;
      READ:    if (issue && beats_left == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port is a pure decode of registered state; req_* never reach it combinationally.
  always_comb begin
    bus.req_ready    = (state == IDLE);
    ram_write_enable = (state == WRITE);
    ram_address      = cur_addr;
    ram_data_in      = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr      <= '0;
      wdata_q       <= '0;
      beats_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      if (accept) begin
        cur_addr <= bus.req_addr;
        if (bus.req_write) wdata_q    <= bus.req_wdata;
        else               beats_left <= bus.req_len;
      end else if (issue) begin
        cur_addr   <= cur_addr + ADDR'(1);
        beats_left <= beats_left - LEN_W'(1);
      end
      inflight <= issue;
      if (issue) inflight_last <= (beats_left == '0);
    end
  end

  // NOTE: FIFO storage has no reset; the empty flag gates its contents off the outputs.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {inflight_last, ram_data_out};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    bus.rsp_valid = !fifo_empty;
    {bus.rsp_last, bus.rsp_data} = fifo_empty ? '0 : fifo_mem[rd_ptr];
    busy = (state != IDLE) || inflight || !fifo_empty;
  end
endmodule

// File: tb/tb_ram_req_ctrl.sv
// Directed bench for ram_req_ctrl with a behavioural single-port RAM
// (1-cycle registered read, write priority, data_out held during writes).
module tb_ram_req_ctrl;
  localparam int ADDR = 8, DATA = 8, LEN_W = 4, FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_req_if #(.ADDR(ADDR), .DATA(DATA), .LEN_W(LEN_W)) bus ();

  logic            ram_write_enable;
  logic [ADDR-1:0] ram_address;
  logic [DATA-1:0] ram_data_in;
  logic [DATA-1:0] ram_data_out = '0;
  logic            busy;

  ram_req_ctrl #(.ADDR(ADDR), .DATA(DATA), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out),
    .busy             (busy)
  );

  logic [DATA-1:0] ram_mem [256];
  always @(posedge clk) begin
    if (ram_write_enable) ram_mem[ram_address] <= ram_data_in;
    else                  ram_data_out <= ram_mem[ram_address];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Response collection and stall-stability monitor, sampled on the falling edge.
  logic [DATA-1:0] got_data [$];
  logic            got_last [$];
  logic            saw_we = 1'b0;
  logic            stall_q = 1'b0;
  logic [DATA:0]   stall_val = '0;

  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      got_data.push_back(bus.rsp_data);
      got_last.push_back(bus.rsp_last);
    end
    if (ram_write_enable) saw_we = 1'b1;
    if (rst_n && stall_q) check("stall_stable", 32'({bus.rsp_last, bus.rsp_data}), 32'(stall_val));
    stall_q   = rst_n && bus.rsp_valid && !bus.rsp_ready;
    stall_val = {bus.rsp_last, bus.rsp_data};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d, input logic [3:0] l);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_len   = l;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 32'(bus.req_ready), 32'(1));
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (got_data.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check("beat_count", 32'(got_data.size()), 32'(n));
  endtask

  task automatic clear_rsp();
    got_data.delete();
    got_last.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp_data",  32'(bus.rsp_data),  32'(0));
    check("rst_rsp_last",  32'(bus.rsp_last),  32'(0));
    check("rst_ram_we",    32'(ram_write_enable), 32'(0));
    check("rst_ram_addr",  32'(ram_address), 32'(0));
    check("rst_ram_din",   32'(ram_data_in), 32'(0));
    check("rst_busy",      32'(busy), 32'(0));
  endtask

  // Expected beat i of a burst is first+i (memory holds value=addr), last only on beat len.
  task automatic check_burst(input string tag, input logic [7:0] first, input int len);
    logic [7:0] exp_d;
    for (int i = 0; i <= len && i < got_data.size(); i++) begin
      exp_d = first + 8'(i);
      check({tag, "_data"}, 32'(got_data[i]), 32'(exp_d));
      check({tag, "_last"}, 32'(got_last[i]), 32'(i == len));
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [3:0] len;
    logic [7:0] first;
  } rd_vec_t;

  rd_vec_t vecs [4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{addr: 8'h00, len: 4'd15, first: 8'h00};
    vecs[1] = '{addr: 8'hFE, len: 4'd3,  first: 8'hFE};
    vecs[2] = '{addr: 8'h05, len: 4'd2,  first: 8'h05};
    vecs[3] = '{addr: 8'h0E, len: 4'd1,  first: 8'h0E};

    for (int i = 0; i < 256; i++) ram_mem[i] = ~8'(i);
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs();
    check("rst_req_ready", 32'(bus.req_ready), 32'(1));
    tick();
    rst_n = 1'b1;

    // Write 0x5A to 0x10, then read it back and check latency and busy.
    tick();
    bus.rsp_ready = 1'b1;
    send(1'b1, 8'h10, 8'h5A, 4'd0);
    @(negedge clk);
    check("wr_we",   32'(ram_write_enable), 32'(1));
    check("wr_addr", 32'(ram_address), 32'(8'h10));
    check("wr_din",  32'(ram_data_in), 32'(8'h5A));
    @(negedge clk);
    check("wr_we_one_cycle", 32'(ram_write_enable), 32'(0));
    tick();
    clear_rsp();
    send(1'b0, 8'h10, 8'h00, 4'd0);
    @(negedge clk);
    check("lat_c1_valid", 32'(bus.rsp_valid), 32'(0));
    @(negedge clk);
    check("lat_c2_valid", 32'(bus.rsp_valid), 32'(0));
    @(negedge clk);
    check("lat_c3_valid", 32'(bus.rsp_valid), 32'(1));
    check("lat_c3_data",  32'(bus.rsp_data), 32'(8'h5A));
    check("lat_c3_last",  32'(bus.rsp_last), 32'(1));
    check("lat_c3_busy",  32'(busy), 32'(1));
    @(negedge clk);
    check("lat_c4_busy",  32'(busy), 32'(0));
    check("lat_c4_valid", 32'(bus.rsp_valid), 32'(0));

    // Fill 0x00-0x0F and 0xFE-0xFF with value=addr.
    for (int a = 0; a < 16; a++) begin
      tick();
      send(1'b1, 8'(a), 8'(a), 4'd0);
    end
    tick();
    send(1'b1, 8'hFE, 8'hFE, 4'd0);
    tick();
    send(1'b1, 8'hFF, 8'hFF, 4'd0);

    // Table-driven bursts with rsp_ready held high.
    for (int v = 0; v < 4; v++) begin
      tick();
      clear_rsp();
      saw_we = 1'b0;
      bus.rsp_ready = 1'b1;
      send(1'b0, vecs[v].addr, 8'h00, vecs[v].len);
      wait_beats(int'(vecs[v].len) + 1, 100);
      check_burst($sformatf("vec%0d", v), vecs[v].first, int'(vecs[v].len));
      check("vec_no_write", 32'(saw_we), 32'(0));
    end

    // Backpressure: only four beats issue against a full credit window.
    tick();
    clear_rsp();
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h00, 8'h00, 4'd7);
    repeat (10) @(negedge clk);
    check("bp_addr_hold", 32'(ram_address), 32'(8'h04));
    check("bp_valid",     32'(bus.rsp_valid), 32'(1));
    check("bp_head",      32'(bus.rsp_data), 32'(8'h00));
    check("bp_busy",      32'(busy), 32'(1));
    repeat (3) @(negedge clk);
    check("bp_addr_hold2", 32'(ram_address), 32'(8'h04));
    for (int c = 0; c < 60 && got_data.size() < 8; c++) begin
      tick();
      bus.rsp_ready = !bus.rsp_ready;
    end
    tick();
    bus.rsp_ready = 1'b1;
    wait_beats(8, 20);
    check_burst("bp", 8'h00, 7);

    // Write to an address whose old data is still queued, then read it again.
    tick();
    clear_rsp();
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h00, 8'h00, 4'd1);
    tick();
    send(1'b1, 8'h00, 8'hA5, 4'd0);
    tick();
    send(1'b0, 8'h00, 8'h00, 4'd0);
    repeat (6) @(negedge clk);
    check("wr_rd_held", 32'(got_data.size()), 32'(0));
    tick();
    bus.rsp_ready = 1'b1;
    wait_beats(3, 50);
    if (got_data.size() == 3) begin
      check("wr_rd_d0", 32'(got_data[0]), 32'(8'h00));
      check("wr_rd_l0", 32'(got_last[0]), 32'(0));
      check("wr_rd_d1", 32'(got_data[1]), 32'(8'h01));
      check("wr_rd_l1", 32'(got_last[1]), 32'(1));
      check("wr_rd_d2", 32'(got_data[2]), 32'(8'hA5));
      check("wr_rd_l2", 32'(got_last[2]), 32'(1));
    end

    // Asynchronous reset during beat 2 of an 8-beat burst.
    tick();
    clear_rsp();
    bus.rsp_ready = 1'b1;
    send(1'b0, 8'h00, 8'h00, 4'd7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    clear_rsp();
    repeat (10) @(negedge clk);
    check("post_rst_no_rsp",  32'(got_data.size()), 32'(0));
    check("post_rst_valid",   32'(bus.rsp_valid), 32'(0));
    check("post_rst_busy",    32'(busy), 32'(0));
    tick();
    send(1'b0, 8'h0A, 8'h00, 4'd1);
    wait_beats(2, 50);
    check_burst("post_rst", 8'h0A, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
